// File: rtl/tybec_stream_pkg.sv
// Shared stream definitions: FloPoCo exception codes and a constant clog2 helper.
package tybec_stream_pkg;

    // FloPoCo two-bit exception field carried above the IEEE payload
    typedef enum logic [1:0] {
        ExcZero   = 2'b00,
        ExcNormal = 2'b01,
        ExcInf    = 2'b10,
        ExcNan    = 2'b11
    } fp_exc_e;

    localparam int unsigned IeeeW    = 32;
    localparam int unsigned FlopocoW = 34;

    // Ceiling log2, usable in parameter expressions
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned res;
        res = 0;
        while ((64'd1 << res) < 64'(value)) begin
            res++;
        end
        return res;
    endfunction

endpackage

// File: rtl/tybec_sync_fifo.sv
// Show-ahead synchronous FIFO. Caller qualifies wr_en with !full and rd_en with !empty.
module tybec_sync_fifo
    import tybec_stream_pkg::*;
#(
    parameter int unsigned WIDTH = 34,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int unsigned PtrW = clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0]  count_q, count_d;

    // Storage array; contents are don't-care until counted as occupied
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr_q] <= wr_data;
        end
    end

    // Next occupancy from the write/read pair
    always_comb begin
        count_d = count_q;
        unique case ({wr_en, rd_en})
            2'b10:   count_d = count_q + CntW'(1);
            2'b01:   count_d = count_q - CntW'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointers wrap naturally since DEPTH is a power of two
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr_q <= wr_ptr_q + PtrW'(1);
            end
            if (rd_en) begin
                rd_ptr_q <= rd_ptr_q + PtrW'(1);
            end
            count_q <= count_d;
        end
    end

    assign full    = (count_q == CntW'(DEPTH));
    assign empty   = (count_q == '0);
    assign rd_data = mem[rd_ptr_q];

endmodule

// File: rtl/kernel_in_stage.sv
// Kernel input stage: IEEE-754 to FloPoCo conversion on write, buffered stream out,
// and a per-frame element counter that pulses done on the last read of each frame.
module kernel_in_stage
    import tybec_stream_pkg::*;
#(
    parameter int unsigned STREAMW = 34,
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned NELEM   = 1024,
    parameter int unsigned FPMODE  = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    input  logic [31:0]        in_data,
    output logic               in_ready,
    output logic               ovalid,
    output logic [STREAMW-1:0] out1_s0,
    input  logic               oready,
    output logic               done
);

    localparam int unsigned CntW = (NELEM > 1) ? clog2(NELEM) : 1;

    logic [7:0]         exp_f;
    logic [22:0]        man_f;
    fp_exc_e            exc;
    logic [31:0]        ieee_word;
    logic [STREAMW-1:0] conv_word;
    logic [STREAMW-1:0] head_word;
    logic               full, empty;
    logic               wr_en, rd_en;
    logic               last_elem;
    logic [CntW-1:0]    frame_cnt_q;

    // Classify the incoming word and build the stored stream element
    always_comb begin
        exp_f     = in_data[30:23];
        man_f     = in_data[22:0];
        exc       = ExcNormal;
        ieee_word = in_data;
        if (exp_f == 8'h00) begin
            // Denormals flush to signed zero
            exc       = ExcZero;
            ieee_word = {in_data[31], 31'b0};
        end else if (exp_f == 8'hFF) begin
            exc = (man_f == '0) ? ExcInf : ExcNan;
        end
        if (FPMODE != 0) begin
            conv_word = STREAMW'({exc, ieee_word});
        end else begin
            conv_word = STREAMW'(in_data);
        end
    end

    // Handshake qualifiers; all outputs forced idle while reset is held
    always_comb begin
        in_ready  = !rst && !full;
        ovalid    = !rst && !empty;
        wr_en     = in_valid && in_ready;
        rd_en     = ovalid && oready;
        last_elem = (frame_cnt_q == CntW'(NELEM - 1));
        done      = rd_en && last_elem;
        out1_s0   = ovalid ? head_word : '0;
    end

    tybec_sync_fifo #(
        .WIDTH (STREAMW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_en),
        .wr_data (conv_word),
        .rd_en   (rd_en),
        .rd_data (head_word),
        .full    (full),
        .empty   (empty)
    );

    // Frame counter advances per read and wraps on the last element
    always_ff @(posedge clk) begin
        if (rst) begin
            frame_cnt_q <= '0;
        end else if (rd_en) begin
            frame_cnt_q <= last_elem ? '0 : frame_cnt_q + CntW'(1);
        end
    end

endmodule

// File: tb/tb_kernel_in_stage.sv
// Randomized self-checking bench for kernel_in_stage against a queue-based reference model.
module tb_kernel_in_stage;

    localparam int unsigned STREAMW = 34;
    localparam int unsigned DEPTH   = 4;
    localparam int unsigned NELEM   = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        oready = 1'b0;
    logic [31:0] in_data = '0;

    logic        in_ready, ovalid, done;
    logic [33:0] out1_s0;
    logic        raw_in_ready, raw_ovalid, raw_done;
    logic [33:0] raw_out1_s0;

    always #5 clk = ~clk;

    kernel_in_stage #(
        .STREAMW (STREAMW),
        .DEPTH   (DEPTH),
        .NELEM   (NELEM),
        .FPMODE  (1)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .ovalid   (ovalid),
        .out1_s0  (out1_s0),
        .oready   (oready),
        .done     (done)
    );

    kernel_in_stage #(
        .STREAMW (STREAMW),
        .DEPTH   (DEPTH),
        .NELEM   (NELEM),
        .FPMODE  (0)
    ) dut_raw (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (raw_in_ready),
        .ovalid   (raw_ovalid),
        .out1_s0  (raw_out1_s0),
        .oready   (oready),
        .done     (raw_done)
    );

    logic [33:0] exp_q[$];
    logic [31:0] raw_q[$];
    logic [31:0] src_q[$];
    int unsigned rd_cnt    = 0;
    int          n_checks  = 0;
    int          n_fail    = 0;
    int          done_seen = 0;

    task automatic check_eq(input string tag, input logic [33:0] got, input logic [33:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference conversion straight from the exception-field rules
    function automatic logic [33:0] ref_conv(input logic [31:0] w);
        logic [7:0]  e;
        logic [22:0] m;
        e = w[30:23];
        m = w[22:0];
        if (e == 8'd0)        return {2'b00, w[31], 31'b0};
        else if (e == 8'd255) return {(m == 23'd0) ? 2'b10 : 2'b11, w};
        else                  return {2'b01, w};
    endfunction

    function automatic logic [31:0] rand_word();
        logic [31:0] w;
        w = $urandom;
        case ($urandom_range(0, 7))
            0: w[30:23] = 8'd0;
            1: begin w[30:23] = 8'd255; w[22:0] = '0; end
            2: begin w[30:23] = 8'd255; w[22:0] = 23'($urandom_range(1, 32'h7FFFFF)); end
            default: ;
        endcase
        return w;
    endfunction

    // One clock: check outputs mid-cycle, then advance the model on the edge
    task automatic tick(output bit acc);
        logic        exp_rdy, exp_vld, exp_done;
        logic [33:0] exp_out, exp_raw;
        @(negedge clk);
        exp_rdy  = !rst && (exp_q.size() < DEPTH);
        exp_vld  = !rst && (exp_q.size() > 0);
        exp_done = exp_vld && oready && (rd_cnt == NELEM - 1);
        if (exp_vld) begin
            exp_out = exp_q[0];
            exp_raw = {2'b00, raw_q[0]};
        end else begin
            exp_out = '0;
            exp_raw = '0;
        end
        check_eq("in_ready", 34'(in_ready), 34'(exp_rdy));
        check_eq("ovalid", 34'(ovalid), 34'(exp_vld));
        check_eq("done", 34'(done), 34'(exp_done));
        check_eq("out1_s0", out1_s0, exp_out);
        check_eq("raw_out1_s0", raw_out1_s0, exp_raw);
        if (done) done_seen++;
        acc = in_valid && exp_rdy;
        @(posedge clk);
        if (rst) begin
            exp_q.delete();
            raw_q.delete();
            rd_cnt = 0;
        end else begin
            if (exp_vld && oready) begin
                void'(exp_q.pop_front());
                void'(raw_q.pop_front());
                rd_cnt = (rd_cnt == NELEM - 1) ? 0 : rd_cnt + 1;
            end
            if (acc) begin
                exp_q.push_back(ref_conv(in_data));
                raw_q.push_back(in_data);
            end
        end
        #1;
    endtask

    task automatic do_reset(input int cycles);
        bit acc;
        rst      = 1'b1;
        in_valid = 1'b0;
        oready   = 1'b0;
        repeat (cycles) tick(acc);
        rst = 1'b0;
    endtask

    // Offer src_q words upstream with given valid/ready probabilities (percent)
    task automatic pump(input int p_valid, input int p_ready, input int max_cycles,
                        input int exp_left);
        bit acc;
        int cyc;
        cyc = 0;
        while (src_q.size() > 0 && cyc < max_cycles) begin
            in_valid = ($urandom_range(0, 99) < p_valid);
            in_data  = in_valid ? src_q[0] : $urandom;
            oready   = ($urandom_range(0, 99) < p_ready);
            tick(acc);
            if (acc) void'(src_q.pop_front());
            cyc++;
        end
        in_valid = 1'b0;
        check_eq("pump_left", 34'(src_q.size()), 34'(exp_left));
    endtask

    task automatic drain(input int max_cycles);
        bit acc;
        int cyc;
        cyc      = 0;
        in_valid = 1'b0;
        oready   = 1'b1;
        while (exp_q.size() > 0 && cyc < max_cycles) begin
            tick(acc);
            cyc++;
        end
        check_eq("drain_left", 34'(exp_q.size()), 34'd0);
    endtask

    initial begin
        bit acc;

        do_reset(3);

        // Single normal word
        src_q.push_back(32'h3F800000);
        pump(100, 100, 5, 0);
        drain(5);

        // Denormal, infinity, NaN
        src_q.push_back(32'h00000001);
        src_q.push_back(32'h7F800000);
        src_q.push_back(32'h7FC00000);
        pump(100, 100, 10, 0);
        drain(10);

        // Backpressure: five words into four slots, then release
        for (int i = 0; i < 5; i++) src_q.push_back(rand_word());
        pump(100, 0, 7, 1);
        pump(100, 100, 20, 0);
        drain(10);

        // Frame boundaries with continuous flow
        do_reset(1);
        done_seen = 0;
        for (int i = 0; i < 7; i++) src_q.push_back(rand_word());
        pump(100, 100, 20, 0);
        drain(10);
        check_eq("frame_dones", 34'(done_seen), 34'd2);

        // Reset mid-frame after two of three reads
        do_reset(1);
        for (int i = 0; i < 3; i++) src_q.push_back(rand_word());
        pump(100, 0, 10, 0);
        in_valid = 1'b0;
        oready   = 1'b1;
        done_seen = 0;
        tick(acc);
        tick(acc);
        rst = 1'b1;
        tick(acc);
        rst    = 1'b0;
        oready = 1'b0;
        tick(acc);
        check_eq("midframe_no_done", 34'(done_seen), 34'd0);
        for (int i = 0; i < 3; i++) src_q.push_back(rand_word());
        pump(100, 100, 10, 0);
        drain(10);
        check_eq("post_reset_dones", 34'(done_seen), 34'd1);

        // Long random run with random stalls on both sides
        for (int i = 0; i < 10000; i++) src_q.push_back(rand_word());
        pump(70, 60, 60000, 0);
        drain(50);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
